// File: rtl/eq_band_scheduler_if.sv
// eq_band_scheduler_if: sample handshake and FIR-engine strobe bundle for the band scheduler.
// master = scheduler side, slave = upstream source / FIR datapath side.
`default_nettype none

interface eq_band_scheduler_if;
  logic        clk_enable;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        in_ready;
  logic [7:0]  band_enable;
  logic        dl_we;
  logic [15:0] dl_data;
  logic [5:0]  tap_idx;
  logic [2:0]  band_sel;
  logic        mac_clr;
  logic        mac_en;
  logic        mac_last;
  logic        band_done;
  logic [2:0]  done_band;
  logic        frame_done;

  modport master (
    input  clk_enable, in_valid, in_sample, band_enable,
    output in_ready, dl_we, dl_data, tap_idx, band_sel,
           mac_clr, mac_en, mac_last, band_done, done_band, frame_done
  );

  modport slave (
    output clk_enable, in_valid, in_sample, band_enable,
    input  in_ready, dl_we, dl_data, tap_idx, band_sel,
           mac_clr, mac_en, mac_last, band_done, done_band, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/eq_band_scheduler.sv
// eq_band_scheduler: time-multiplexes one serial 63-tap MAC engine across the enabled EQ bands.
// Rev 1.0
`default_nettype none

module eq_band_scheduler #(
  parameter int NUM_TAPS  = 63,
  parameter int NUM_BANDS = 8,
  parameter int MAC_LAT   = 2
) (
  input wire                  clk,
  input wire                  rst,
  eq_band_scheduler_if.master bus
);

  localparam int             c_DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [5:0]     c_LAST_TAP   = 6'(NUM_TAPS - 1);
  localparam logic [c_DW-1:0] c_LAST_DRAIN = c_DW'(MAC_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [5:0]      r_tap;
  logic [2:0]      r_band_sel;
  logic [7:0]      r_mask;
  logic [15:0]     r_dl_data;
  logic [c_DW-1:0] r_drain;

  logic [2:0] w_first_band;
  logic [2:0] w_next_band;
  logic       w_has_next;
  logic       w_mask_nz;
  logic       w_tap_last;
  logic       w_drain_last;

  logic w_in_ready;
  logic w_dl_we;
  logic w_mac_en;
  logic w_mac_clr;
  logic w_mac_last;
  logic w_band_done;
  logic w_frame_done;

  assign w_mask_nz  = (r_mask != 8'd0);
  assign w_tap_last = (r_tap == c_LAST_TAP);
  // An empty frame passes through a single DRAIN cycle to signal frame_done without a band.
  assign w_drain_last = !w_mask_nz || (r_drain == c_LAST_DRAIN);

  // Descending scan so the final assignment is the lowest qualifying band.
  always_comb begin
    w_first_band = 3'd0;
    w_next_band  = r_band_sel;
    w_has_next   = 1'b0;
    for (int b = NUM_BANDS - 1; b >= 0; b--) begin
      if (r_mask[b]) begin
        w_first_band = 3'(b);
      end
      if (r_mask[b] && (b > int'(r_band_sel))) begin
        w_has_next  = 1'b1;
        w_next_band = 3'(b);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.clk_enable) begin
      case (r_state)
        S_IDLE:  if (bus.in_valid) w_next_state = S_LOAD;
        S_LOAD:  w_next_state = w_mask_nz ? S_RUN : S_DRAIN;
        S_RUN:   if (w_tap_last) w_next_state = S_DRAIN;
        S_DRAIN: if (w_drain_last) w_next_state = w_has_next ? S_RUN : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready   = (r_state == S_IDLE);
    w_dl_we      = (r_state == S_LOAD) && bus.clk_enable;
    w_mac_en     = (r_state == S_RUN) && bus.clk_enable;
    w_mac_clr    = w_mac_en && (r_tap == 6'd0);
    w_mac_last   = w_mac_en && w_tap_last;
    w_band_done  = (r_state == S_DRAIN) && w_drain_last && w_mask_nz && bus.clk_enable;
    w_frame_done = (r_state == S_DRAIN) && w_drain_last && !w_has_next && bus.clk_enable;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tap      <= 6'd0;
      r_band_sel <= 3'd0;
      r_mask     <= 8'd0;
      r_dl_data  <= 16'd0;
      r_drain    <= '0;
    end else if (bus.clk_enable) begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_dl_data <= bus.in_sample;
            r_mask    <= bus.band_enable;
          end
        end
        S_LOAD: begin
          r_tap   <= 6'd0;
          r_drain <= '0;
          if (w_mask_nz) r_band_sel <= w_first_band;
        end
        S_RUN: begin
          r_drain <= '0;
          if (!w_tap_last) r_tap <= r_tap + 6'd1;
        end
        S_DRAIN: begin
          if (!w_drain_last) begin
            r_drain <= r_drain + 1'b1;
          end else begin
            r_tap   <= 6'd0;
            r_drain <= '0;
            if (w_has_next) r_band_sel <= w_next_band;
          end
        end
        default: r_tap <= 6'd0;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.dl_we      = w_dl_we;
  assign bus.dl_data    = r_dl_data;
  assign bus.tap_idx    = r_tap;
  assign bus.band_sel   = r_band_sel;
  assign bus.mac_clr    = w_mac_clr;
  assign bus.mac_en     = w_mac_en;
  assign bus.mac_last   = w_mac_last;
  assign bus.band_done  = w_band_done;
  assign bus.done_band  = r_band_sel;
  assign bus.frame_done = w_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_eq_band_scheduler.sv
// tb_eq_band_scheduler: directed cycle-accurate checks of the band scheduler against a timing model.
`default_nettype none

module tb_eq_band_scheduler;

  localparam int MAC_LAT   = 2;
  localparam int NUM_TAPS  = 63;
  localparam int BAND_SLOT = NUM_TAPS + MAC_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eq_band_scheduler_if bus ();

  eq_band_scheduler #(
    .NUM_TAPS (NUM_TAPS),
    .NUM_BANDS(8),
    .MAC_LAT  (MAC_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int bands[8];
  int n_bands;
  int mac_en_cnt;
  int band_done_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit layout: rdy[18] dl_we[17] mac_en[16] mac_clr[15] mac_last[14] band_done[13] frame_done[12]
  // tap[11:6] band_sel[5:3] done_band[2:0]
  function automatic logic [31:0] pack(input logic rdy, input logic dlwe, input logic en,
                                       input logic clr, input logic last, input logic bd,
                                       input logic fd, input logic [5:0] tap,
                                       input logic [2:0] bs, input logic [2:0] db);
    return {13'd0, rdy, dlwe, en, clr, last, bd, fd, tap, bs, db};
  endfunction

  function automatic logic [31:0] observed(input logic [31:0] e);
    return pack(bus.in_ready, bus.dl_we, bus.mac_en, bus.mac_clr, bus.mac_last,
                bus.band_done, bus.frame_done,
                e[16] ? bus.tap_idx : 6'd0,
                e[16] ? bus.band_sel : 3'd0,
                e[13] ? bus.done_band : 3'd0);
  endfunction

  function automatic logic [31:0] raw_outputs();
    return pack(bus.in_ready, bus.dl_we, bus.mac_en, bus.mac_clr, bus.mac_last,
                bus.band_done, bus.frame_done, bus.tap_idx, bus.band_sel, bus.done_band);
  endfunction

  function automatic logic [31:0] reset_vec();
    return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 3'd0);
  endfunction

  // Expected outputs for enabled cycle c after the acceptance edge.
  function automatic logic [31:0] expected(input int c, input int endc);
    int rel;
    int k;
    int r;
    logic fin;
    if (c == endc) return reset_vec();
    if (c == 1) return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 3'd0);
    if (n_bands == 0)
      return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (c == 2), 6'd0, 3'd0, 3'd0);
    rel = c - 2;
    k   = rel / BAND_SLOT;
    r   = rel % BAND_SLOT;
    if (r < NUM_TAPS)
      return pack(1'b0, 1'b0, 1'b1, (r == 0), (r == NUM_TAPS - 1), 1'b0, 1'b0,
                  6'(r), 3'(bands[k]), 3'd0);
    fin = (r == BAND_SLOT - 1);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fin, fin && (k == n_bands - 1),
                6'd0, 3'd0, fin ? 3'(bands[k]) : 3'd0);
  endfunction

  task automatic set_bands(input logic [7:0] mask);
    n_bands = 0;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) begin
        bands[n_bands] = b;
        n_bands++;
      end
    end
  endtask

  // Entry: #1 after a posedge with the sample already offered (or, with skip0,
  // #1 after the acceptance edge). Exit: #1 after the edge ending the in_ready cycle.
  task automatic run_frame(input logic [7:0] mask, input logic [15:0] sample,
                           input bit stall, input bit hold, input bit skip0,
                           input logic [7:0] mid_mask, input logic [15:0] mid_sample);
    int cyc;
    int guard;
    int endc;
    logic [31:0] e;
    cyc   = 0;
    guard = 0;
    set_bands(mask);
    endc = (n_bands == 0) ? 3 : 2 + n_bands * BAND_SLOT;
    if (!skip0) begin
      @(negedge clk);
      check("rdy0", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    if (!hold) bus.in_valid = 1'b0;
    while (cyc < endc && guard < 20 * endc) begin
      guard++;
      bus.clk_enable = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold && cyc == 100) begin
        bus.band_enable = mid_mask;
        bus.in_sample   = mid_sample;
      end
      @(negedge clk);
      if (bus.clk_enable) begin
        cyc++;
        e = expected(cyc, endc);
        check($sformatf("cyc%0d", cyc), observed(e), e);
        if (cyc == 1) check("dl_data", {16'd0, bus.dl_data}, {16'd0, sample});
        mac_en_cnt    += int'(bus.mac_en);
        band_done_cnt += int'(bus.band_done);
      end else begin
        check("stall", observed(32'd0),
              pack((cyc + 1 == endc), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 3'd0));
      end
      @(posedge clk);
      #1;
    end
    if (cyc < endc) check("timeout", 32'(cyc), 32'(endc));
    bus.clk_enable = 1'b1;
  endtask

  initial begin
    bus.clk_enable  = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_sample   = 16'd0;
    bus.band_enable = 8'd0;
    mac_en_cnt      = 0;
    band_done_cnt   = 0;
    #1 rst = 1'b0;
    #11;
    check("rst_out", raw_outputs(), reset_vec());
    check("rst_dl_data", {16'd0, bus.dl_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // All eight bands
    bus.in_valid = 1'b1; bus.in_sample = 16'h1234; bus.band_enable = 8'hFF;
    run_frame(8'hFF, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Sparse mask: bands 0, 2, 7
    bus.in_valid = 1'b1; bus.in_sample = 16'h0BCD; bus.band_enable = 8'b1000_0101;
    run_frame(8'b1000_0101, 16'h0BCD, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Empty mask
    bus.in_valid = 1'b1; bus.in_sample = 16'hFFFF; bus.band_enable = 8'h00;
    run_frame(8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Random clk_enable stalls across a full frame
    mac_en_cnt = 0; band_done_cnt = 0;
    bus.in_valid = 1'b1; bus.in_sample = 16'h7FFF; bus.band_enable = 8'hFF;
    run_frame(8'hFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("mac_en_cnt", 32'(mac_en_cnt), 32'd504);
    check("band_done_cnt", 32'(band_done_cnt), 32'd8);

    // Reset during band 3, tap 40
    bus.in_valid = 1'b1; bus.in_sample = 16'h8000; bus.band_enable = 8'hFF;
    @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (236) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst", {22'd0, bus.mac_en, bus.tap_idx, bus.band_sel}, {22'd0, 1'b1, 6'd40, 3'd3});
    #1 rst = 1'b0;
    #1;
    check("rst_mid", raw_outputs(), reset_vec());
    check("rst_mid_dl_data", {16'd0, bus.dl_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", raw_outputs(), reset_vec());
    end
    @(posedge clk);
    #1;

    // Normal frame after the abandoned one
    bus.in_valid = 1'b1; bus.in_sample = 16'h4321; bus.band_enable = 8'hFF;
    run_frame(8'hFF, 16'h4321, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // in_valid held high: inputs change mid-frame, next acceptance at the in_ready cycle
    bus.in_valid = 1'b1; bus.in_sample = 16'hA5A5; bus.band_enable = 8'b1000_0101;
    run_frame(8'b1000_0101, 16'hA5A5, 1'b0, 1'b1, 1'b0, 8'h0F, 16'h5A5A);
    run_frame(8'h0F, 16'h5A5A, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eq_band_scheduler.md
# eq_band_scheduler

Sequencing controller for the 8-band equalizer's shared serial FIR engine. One 63-tap multiply-accumulate datapath (delay line, per-band coefficient ROM, accumulator) is time-multiplexed across all bands. For each accepted audio sample, this block writes the sample into the delay line once. It then sweeps the tap index 0..62 for every enabled band in ascending order, driving the accumulator strobes and pulsing a per-band done flag when each band's result is valid.

## Interface
Parameters:
- NUM_TAPS, 63, taps per band filter
- NUM_BANDS, 8, equalizer bands
- MAC_LAT, 2, accumulator pipeline depth in enabled cycles, from last tap issue to result valid (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; asynchronous, active-low
- clk_enable  in  1  global advance enable; the block holds all state while low
- in_valid  in  1  new sample offered
- in_sample  in  16  signed sample
- in_ready  out  1  scheduler idle; can accept a sample
- band_enable  in  8  band mask; bit b=1 means band b is computed
- dl_we  out  1  delay-line write/shift strobe
- dl_data  out  16  latched sample for the delay line
- tap_idx  out  6  coefficient/delay-line tap address
- band_sel  out  3  coefficient bank select
- mac_clr  out  1  load accumulator with the product instead of adding it (first tap)
- mac_en  out  1  accumulate the current tap
- mac_last  out  1  last tap of the current band
- band_done  out  1  result of band done_band is valid this cycle
- done_band  out  3  band index qualifying band_done
- frame_done  out  1  all enabled bands for this sample have finished

## Operation
- State machine: IDLE, LOAD, RUN, DRAIN.
- **IDLE**
  - in_ready=1.
  - A sample is accepted at the edge where in_valid & in_ready & clk_enable.
  - On acceptance: latch in_sample into dl_data and band_enable into an internal mask, then go to LOAD.
- **LOAD**
  - dl_we=1 for one enabled cycle.
  - If the mask is nonzero, go to RUN with band_sel = lowest set bit and tap counter = 0.
  - If the mask is zero, pulse frame_done in the next cycle (from IDLE entry) and return to IDLE; no band_done is issued.
- **RUN**
  - mac_en=1 and tap_idx = tap counter.
  - mac_clr=1 when tap_idx=0; mac_last=1 when tap_idx=NUM_TAPS-1.
  - After tap NUM_TAPS-1, go to DRAIN with the drain counter = 0.
- **DRAIN**
  - Lasts MAC_LAT cycles. On the last drain cycle: band_done=1 and done_band=band_sel.
  - Then go to RUN on the next higher set mask bit, with the tap counter cleared.
  - If no higher bit is set, assert frame_done in the same cycle as that band_done and go to IDLE.
- Strobe gating: dl_we, mac_en, mac_clr, mac_last, band_done and frame_done are ANDed with clk_enable. No strobe repeats while stalled.
- Width rules:
  - The tap counter is 6-bit and never exceeds NUM_TAPS-1; there is no wrap to 63.
  - band_sel/done_band are 3-bit.
  - Skipped bands never appear on band_sel while mac_en=1.
- Held values:
  - band_enable or in_sample changing mid-frame has no effect until the next acceptance.
  - in_valid while in_ready=0 is ignored; the upstream holds it.
- Reset (async, rst=0) forces:
  - IDLE; in_ready=1.
  - All strobes 0; tap_idx=0, band_sel=0, done_band=0, dl_data=0; mask cleared.
- Reset mid-frame abandons the frame: no band_done and no frame_done for it.

## Timing
- Counting is in clk_enable-high cycles. Acceptance edge = E0.
- Cycle 1: LOAD (dl_we).
- Cycles 2..64: first enabled band, taps 0..62.
- DRAIN for the first band: cycles 65..(64+MAC_LAT).
- Band_done for the k-th enabled band (k from 0): cycle 64 + MAC_LAT + k·(63+MAC_LAT).
- All 8 bands enabled, MAC_LAT=2:
  - Last band_done and frame_done at cycle 521.
  - in_ready=1 at cycle 522.
  - Maximum sustainable input rate is 1 sample per 522 enabled cycles.
- Back-to-back: in_ready rises in the cycle after frame_done. A sample held valid is accepted at that cycle's edge, so there is no bubble beyond that cycle.

## Test plan
- Reset release, band_enable=8'hFF, one sample 16'sh1234 with MAC_LAT=2:
  - dl_we at cycle 1 with dl_data=16'h1234.
  - mac_clr at cycles 2, 67, 132, …
  - band_done at cycles 66, 131, …, 521 with done_band 0..7.
  - frame_done only at 521.
- band_enable=8'b1000_0101:
  - Only bands 0, 2, 7 are swept, in that order.
  - band_done at cycles 66, 131, 196; frame_done at 196.
- band_enable=0: dl_we at cycle 1, frame_done at cycle 2, no mac_en, in_ready=1 at cycle 3.
- clk_enable toggled pseudo-randomly (50%) during an all-band frame:
  - Exactly 63 mac_en pulses per band and 8 band_done pulses.
  - Enabled-cycle positions match the unstalled run.
- rst asserted during band 3, tap 40:
  - Outputs immediately take reset values; no band_done/frame_done for that frame.
  - The next sample runs a complete normal frame.
- in_valid held high continuously with changing in_sample:
  - Second acceptance occurs exactly at the cycle after frame_done.
  - band_enable changes mid-frame do not alter the current sweep.
